result_port_arbiter: RTL and testbench

RESULT_PORT_ARBITER -- requirements
Module: result_port_arbiter

---
 rtl/result_arbiter_pkg.sv | 32 +++
 rtl/result_skid_fifo.sv | 46 ++++
 rtl/result_port_arbiter.sv | 133 +++++++++++++
 tb/tb_result_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/result_arbiter_pkg.sv
// Shared types for the result port arbiter: operand/result select fields,
// the bundle carried to the result selecter, and the starvation FSM states.
package result_arbiter_pkg;

    typedef enum logic [1:0] {SIGN_RESULT, SIGN_OP_A, SIGN_OP_B, SIGN_ZERO} sign_select_t;
    typedef enum logic [1:0] {EXP_RESULT, EXP_OP_A, EXP_OP_B, EXP_ZERO} exponent_select_t;
    typedef enum logic [1:0] {FMSB_RESULT, FMSB_OP_A, FMSB_OP_B, FMSB_ONE} fraction_msb_select_t;
    typedef enum logic [1:0] {FLSB_RESULT, FLSB_OP_A, FLSB_OP_B, FLSB_ZERO} fraction_lsbs_select_t;

    typedef struct packed {
        sign_select_t          sign_sel;
        exponent_select_t      exponent_sel;
        fraction_msb_select_t  fraction_msb_sel;
        fraction_lsbs_select_t fraction_lsbs_sel;
        logic                  a_sign;
        logic [7:0]            a_exponent;
        logic [22:0]           a_fraction;
        logic                  b_sign;
        logic [7:0]            b_exponent;
        logic [22:0]           b_fraction;
        logic                  res_sign;
        logic [9:0]            res_exponent;
        logic [24:0]           res_fraction;
    } result_bundle_t;

    // Starvation tracking for results waiting behind the pipe path.
    typedef enum logic [1:0] {IDLE, WAIT, STALL, DRAIN} arb_state_t;

    // Wide enough for any sensible STARVE_LIMIT / ISSUE_LATENCY.
    localparam int CNT_W = 8;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO buffering div/sqrt results while the pipe path owns the port.
module result_skid_fifo
    import result_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  result_bundle_t push_data,
    input  logic           pop,
    output result_bundle_t head,
    output logic           empty,
    output logic           full
);

    result_bundle_t mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;

    // Pointer and occupancy tracking; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/result_port_arbiter.sv
// Merges the unstallable add/mul pipe and the div/sqrt unit onto one result
// port. Pipe results always win; iter results wait in a skid FIFO, and if they
// starve too long a one-cycle issue bubble is requested to make room.
module result_port_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT  = 4,
    parameter int ISSUE_LATENCY = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pipe_valid,
    input  result_bundle_t pipe_bundle,
    input  logic           iter_valid,
    input  result_bundle_t iter_bundle,
    output logic           iter_ready,
    output logic           issue_stall,
    output logic           out_valid,
    output result_bundle_t out_bundle,
    output logic           out_source
);

    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(ISSUE_LATENCY);

    result_bundle_t   fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             blocked;
    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // An iter result arriving to an idle port with nothing buffered goes
    // straight to the output register instead of through the FIFO.
    assign iter_ready = ~fifo_full;
    assign pop        = ~pipe_valid & ~fifo_empty;
    assign bypass     = ~pipe_valid & fifo_empty & iter_valid;
    assign push       = iter_valid & iter_ready & ~bypass;
    assign blocked    = pipe_valid & ~fifo_empty;

    result_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (iter_bundle),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Output register: pipe first, then buffered iter, then a bypassed iter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_source <= 1'b0;
            out_bundle <= '0;
        end else if (pipe_valid) begin
            out_valid  <= 1'b1;
            out_source <= 1'b0;
            out_bundle <= pipe_bundle;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_source <= 1'b1;
            out_bundle <= fifo_head;
        end else if (bypass) begin
            out_valid  <= 1'b1;
            out_source <= 1'b1;
            out_bundle <= iter_bundle;
        end else begin
            out_valid  <= 1'b0;
        end
    end

    // Starvation FSM state and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: count blocked cycles, request one bubble, then give the
    // bubble ISSUE_LATENCY cycles to reach the port before re-arming.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        issue_stall = 1'b0;
        case (state)
            IDLE: begin
                if (blocked) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (pop) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt_next >= STARVE_LAST) state_next = STALL;
                end
            end
            STALL: begin
                issue_stall = 1'b1;
                state_next  = DRAIN;
                cnt_next    = '0;
            end
            DRAIN: begin
                if (pop || cnt >= DRAIN_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_result_port_arbiter.sv
// Directed bench for result_port_arbiter: a scoreboard of pipe and iter
// results is filled on each handshake and drained as the output port fires.
module tb_result_port_arbiter;
    import result_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pipe_valid = 1'b0;
    logic           iter_valid = 1'b0;
    result_bundle_t pipe_bundle = '0;
    result_bundle_t iter_bundle = '0;
    logic           iter_ready;
    logic           issue_stall;
    logic           out_valid;
    logic           out_source;
    result_bundle_t out_bundle;

    result_bundle_t pipe_q[$];
    result_bundle_t iter_q[$];
    int n_checks  = 0;
    int n_err     = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    int stall_cyc = -1;
    int blk       = 0;

    always #5 clk = ~clk;

    result_port_arbiter #(.STARVE_LIMIT(4), .ISSUE_LATENCY(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_valid  (pipe_valid),
        .pipe_bundle (pipe_bundle),
        .iter_valid  (iter_valid),
        .iter_bundle (iter_bundle),
        .iter_ready  (iter_ready),
        .issue_stall (issue_stall),
        .out_valid   (out_valid),
        .out_bundle  (out_bundle),
        .out_source  (out_source)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_bundle_t rnd();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return result_bundle_t'(r[$bits(result_bundle_t)-1:0]);
    endfunction

    // One clock: log handshakes into the scoreboard, then check the port.
    task automatic tick();
        logic pv;
        pv = pipe_valid & ~reset;
        if (pv) pipe_q.push_back(pipe_bundle);
        if (iter_valid && iter_ready && !reset) iter_q.push_back(iter_bundle);
        @(posedge clk);
        #1;
        cyc++;
        if (issue_stall) begin
            stall_cnt++;
            stall_cyc = cyc;
        end
        if (pv) begin
            chk("pipe_slot", {out_valid, out_source}, 2'b10);
            chk("pipe_data", out_bundle, pipe_q.pop_front());
        end else if (out_valid) begin
            chk("iter_src", out_source, 1'b1);
            chk("iter_pending", iter_q.size() > 0, 1'b1);
            if (iter_q.size() > 0) chk("iter_data", out_bundle, iter_q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", iter_ready, 1'b1);
        chk("rst_stall", issue_stall, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_source", out_source, 1'b0);
        chk("rst_bundle", out_bundle, '0);
        reset = 1'b0;

        // Lone iter result, pipe idle: out one cycle later, nothing buffered
        iter_valid = 1'b1; iter_bundle = rnd();
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_source", out_source, 1'b1);
        iter_valid = 1'b0;
        tick();
        chk("t1_idle", out_valid, 1'b0);
        chk("t1_ready", iter_ready, 1'b1);

        // Pipe and iter together: pipe first, iter on the next idle cycle
        pipe_valid = 1'b1; pipe_bundle = rnd();
        iter_valid = 1'b1; iter_bundle = rnd();
        tick();
        chk("t2_pipe_first", out_source, 1'b0);
        pipe_valid = 1'b0; iter_valid = 1'b0;
        tick();
        chk("t2_iter_next", {out_valid, out_source}, 2'b11);
        tick();
        chk("t2_idle", out_valid, 1'b0);

        // Two buffered under a busy pipe: FIFO full, third offer held
        pipe_valid = 1'b1; pipe_bundle = rnd();
        iter_valid = 1'b1; iter_bundle = rnd();
        tick();
        pipe_bundle = rnd(); iter_bundle = rnd();
        tick();
        chk("t3_full", iter_ready, 1'b0);
        pipe_bundle = rnd(); iter_bundle = rnd();
        tick();
        chk("t3_held", iter_ready, 1'b0);
        pipe_valid = 1'b0;
        tick();
        chk("t3_pop_frees", iter_ready, 1'b1);
        tick();
        iter_valid = 1'b0;
        tick();
        tick();
        chk("t3_drained", out_valid, 1'b0);
        chk("t3_no_stall", stall_cnt, 0);

        // Starvation: stall 4 cycles after first blocked cycle, bubble 3 later
        pipe_valid = 1'b1; pipe_bundle = rnd();
        iter_valid = 1'b1; iter_bundle = rnd();
        tick();
        iter_valid = 1'b0;
        blk = cyc;
        stall_cnt = 0;
        while (cyc < blk + 7) begin
            pipe_bundle = rnd();
            tick();
        end
        chk("t4_stall_cycle", stall_cyc, blk + 4);
        chk("t4_stall_once", stall_cnt, 1);
        pipe_valid = 1'b0;
        tick();
        chk("t4_bubble_iter", {out_valid, out_source}, 2'b11);
        pipe_valid = 1'b1;
        repeat (6) begin
            pipe_bundle = rnd();
            tick();
        end
        chk("t4_no_restall", stall_cnt, 1);

        // Bubble arrives early in DRAIN: pop, back to IDLE, no second stall
        iter_valid = 1'b1; iter_bundle = rnd(); pipe_bundle = rnd();
        tick();
        iter_valid = 1'b0;
        blk = cyc;
        stall_cnt = 0;
        while (cyc < blk + 5) begin
            pipe_bundle = rnd();
            tick();
        end
        chk("t5_stall_cycle", stall_cyc, blk + 4);
        pipe_valid = 1'b0;
        tick();
        chk("t5_early_pop", {out_valid, out_source}, 2'b11);
        pipe_valid = 1'b1;
        repeat (8) begin
            pipe_bundle = rnd();
            tick();
        end
        chk("t5_single_stall", stall_cnt, 1);

        // Reset while two results are buffered and the FSM is waiting
        stall_cnt = 0;
        iter_valid = 1'b1; iter_bundle = rnd(); pipe_bundle = rnd();
        tick();
        iter_bundle = rnd(); pipe_bundle = rnd();
        tick();
        iter_valid = 1'b0; pipe_bundle = rnd();
        tick();
        chk("t6_full", iter_ready, 1'b0);
        pipe_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_ready", iter_ready, 1'b1);
        chk("t6_rst_stall", issue_stall, 1'b0);
        chk("t6_rst_bundle", out_bundle, '0);
        iter_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin
            tick();
            chk("t6_no_iter", out_valid, 1'b0);
        end
        chk("t6_no_stall", stall_cnt, 0);
        chk("t6_ready", iter_ready, 1'b1);

        chk("sb_iter_empty", iter_q.size(), 0);
        chk("sb_pipe_empty", pipe_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
